uart_rx_byte: RTL and testbench

- Asynchronous-serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, idle-high line.
- Pairs with the existing byte transmitter. It samples the external RX pin and delivers each received byte to the top level with a one-cycle done strobe.
- It also flags framing errors.
- Baud timing is generated internally. No separate bps module is instantiated.

---
 rtl/uart_rx_byte.sv | 125 ++++++++++++
 tb/tb_uart_rx_byte.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 asynchronous serial receiver with internal baud timing.
// Delivers each correctly framed byte with a one-cycle done strobe; stop-bit errors raise an error strobe.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sclk,
  input  logic       RSTn,
  input  logic       RX_Pin_In,
  input  logic       RX_En_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       RX_Err_Sig
);
  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] SAMPLE = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] LAST   = CW'(BIT_CNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          s1_q, s2_q, s3_q;

  logic rx_s, start_edge, at_sample, at_last;
  assign rx_s       = s2_q;
  assign start_edge = s3_q & ~s2_q;
  assign at_sample  = (cnt_q == SAMPLE);
  assign at_last    = (cnt_q == LAST);

  // Synchronizer resets high so release from reset never looks like a start edge.
  always_ff @(posedge sclk or negedge RSTn) begin
    if (!RSTn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= RX_Pin_In;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (RX_En_Sig && start_edge) state_d = START;
      START: begin
        if (at_sample && rx_s) state_d = IDLE;
        else if (at_last) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (at_sample) shreg_d = {rx_s, shreg_q[7:1]};
        if (at_last) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      // Leave at mid-stop so a back-to-back start edge at the next boundary is caught.
      STOP: begin
        if (at_sample) begin
          if (rx_s) begin
            data_d  = shreg_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!RX_En_Sig && state_q != IDLE) begin
      state_d = IDLE;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    if (state_d != state_q || state_q == IDLE || state_q == WAIT_IDLE) cnt_d = '0;
    else if (at_last)                                                  cnt_d = '0;
    else                                                               cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sclk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign RX_Data     = data_q;
  assign RX_Done_Sig = done_q;
  assign RX_Err_Sig  = err_q;
endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized + directed bench for uart_rx_byte; expected frames queued at send time, checked by a monitor.
module tb_uart_rx_byte;
  localparam int BIT_CNT = 10;
  localparam int LAT     = 3 + 9 * BIT_CNT + BIT_CNT / 2;

  logic       sclk = 1'b0;
  logic       RSTn = 1'b0;
  logic       RX_Pin_In = 1'b1;
  logic       RX_En_Sig = 1'b1;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig, RX_Err_Sig;

  uart_rx_byte #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) dut (
    .sclk(sclk), .RSTn(RSTn), .RX_Pin_In(RX_Pin_In), .RX_En_Sig(RX_En_Sig),
    .RX_Data(RX_Data), .RX_Done_Sig(RX_Done_Sig), .RX_Err_Sig(RX_Err_Sig)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    longint     t0;
  } exp_t;

  exp_t       exp_q[$];
  longint     cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input int n);
    RX_Pin_In = v;
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // Reference model: a frame's outcome depends only on its stop bit;
  // good frames become the new last_good, bad frames leave it alone.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.err  = !stop_ok;
      e.data = stop_ok ? d : last_good;
      e.t0   = cyc;
      exp_q.push_back(e);
      if (stop_ok) last_good = d;
    end
    drive(1'b0, BIT_CNT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT_CNT);
    drive(stop_ok, BIT_CNT);
  endtask

  // Monitor
  logic prev_pulse = 1'b0;
  always @(negedge sclk) begin
    if (RSTn) begin
      if (RX_Done_Sig || RX_Err_Sig) begin
        exp_t e;
        chk("done_err_exclusive", {RX_Done_Sig, RX_Err_Sig} == 2'b11, 0);
        chk("pulse_width", prev_pulse, 0);
        if (!prev_pulse) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind_err", RX_Err_Sig, e.err);
            chk("rx_data", RX_Data, e.data);
            n_vec++;
            if (cyc - e.t0 < LAT - 1 || cyc - e.t0 > LAT + 1) begin
              n_err++;
              $display("FAIL latency: got %0d expected %0d+-1", cyc - e.t0, LAT);
            end
          end
        end
      end
      prev_pulse <= RX_Done_Sig | RX_Err_Sig;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  initial begin
    repeat (80000) @(posedge sclk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sclk);
    #1;
    chk("reset_data", RX_Data, 8'h00);
    chk("reset_done", RX_Done_Sig, 0);
    chk("reset_err", RX_Err_Sig, 0);
    RSTn = 1'b1;
    drive(1'b1, 20);

    // Reset mid-frame: partial frame, reset, then quiet line
    drive(1'b0, BIT_CNT);
    drive(1'b1, BIT_CNT);
    drive(1'b0, 15);
    RSTn = 1'b0;
    RX_Pin_In = 1'b1;
    drive(1'b1, 3);
    RSTn = 1'b1;
    drive(1'b1, 200);
    chk("post_reset_data", RX_Data, 8'h00);
    chk("post_reset_queue", exp_q.size(), 0);

    // Single frame
    send_frame(8'hA5, 1'b1, 1'b1);
    drive(1'b1, 30);
    chk("single_data", RX_Data, 8'hA5);

    // Back-to-back
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    drive(1'b1, 30);

    // Start glitch
    drive(1'b0, 3);
    drive(1'b1, 40);
    send_frame(8'h55, 1'b1, 1'b1);
    drive(1'b1, 20);

    // Framing error with long low hold
    send_frame(8'h5A, 1'b0, 1'b1);
    drive(1'b0, 30);
    drive(1'b1, 2 * BIT_CNT);
    chk("ferr_data_held", RX_Data, 8'h55);
    send_frame(8'h81, 1'b1, 1'b1);
    drive(1'b1, 20);

    // Enable abort during data bit 3
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        repeat (BIT_CNT * 4 + 3) @(posedge sclk);
        #1;
        RX_En_Sig = 1'b0;
      end
    join
    drive(1'b1, 20);
    RX_En_Sig = 1'b1;
    drive(1'b1, 20);
    chk("abort_data_held", RX_Data, 8'h81);
    send_frame(8'h7E, 1'b1, 1'b1);
    drive(1'b1, 20);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      bit ok;
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(d, ok, 1'b1);
      if (!ok) begin
        drive(1'b0, $urandom_range(0, 25));
        drive(1'b1, BIT_CNT + $urandom_range(0, 10));
      end else begin
        drive(1'b1, $urandom_range(0, 25));
      end
    end

    drive(1'b1, 200);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_data", RX_Data, last_good);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
